pad_poll_sequencer: RTL and testbench

//  Periodically polls the attached NES or SNES game pad over its serial

---
 rtl/pad_pkg.sv | 26 ++
 rtl/pad_poll_timer.sv | 23 ++
 rtl/pad_poll_sequencer.sv | 127 ++++++++++++
 tb/tb_pad_poll_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pad_pkg.sv
// Shared types and helpers for the NES/SNES game pad poller.
package pad_pkg;

  typedef enum logic [1:0] {
    PAD_NES  = 2'b00,
    PAD_SNES = 2'b01
  } pad_type_e;

  localparam int NES_BITS  = 8;
  localparam int SNES_BITS = 16;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_LO,
    CLK_HI,
    DONE
  } pad_state_e;

  // Pad lines are active-low; NES only fills the low byte.
  function automatic logic [15:0] pad_buttons(input pad_type_e t, input logic [15:0] sh);
    if (t == PAD_NES) return {8'h00, ~sh[7:0]};
    return ~sh;
  endfunction

endpackage

// File: rtl/pad_poll_timer.sv
// Free-running poll-rate counter; tick marks the last count of each period.
module pad_poll_timer #(
  parameter int POLL_CYC = 833_333
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(POLL_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)            cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/pad_poll_sequencer.sv
// Polls an NES/SNES pad over latch/clock/data and publishes an active-high
// button word with a one-cycle valid strobe.
module pad_poll_sequencer #(
  parameter int POLL_CYC  = 833_333,
  parameter int LATCH_CYC = 600,
  parameter int HALF_CYC  = 300
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  sel,
  input  logic        poll_en,
  input  logic        pad_data,
  output logic        pad_latch,
  output logic        pad_clk,
  output logic [15:0] buttons,
  output logic        valid,
  output logic        busy
);
  import pad_pkg::*;

  localparam int PMAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
  localparam int PW   = $clog2(PMAX);
  localparam logic [PW-1:0] LATCH_LAST = PW'(LATCH_CYC - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_CYC - 1);

  logic            tick;
  logic            sync_p0, sync_p1;
  pad_state_e      state;
  pad_type_e       ptype;
  logic [PW-1:0]   phase;
  logic [4:0]      bit_idx;
  logic [4:0]      last_bit;
  logic [15:0]     shift;

  pad_poll_timer #(.POLL_CYC(POLL_CYC)) u_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Stage p0/p1: two-flop synchronizer for the asynchronous pad data line
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= pad_data;
      sync_p1 <= sync_p0;
    end
  end

  assign last_bit = (ptype == PAD_NES) ? 5'(NES_BITS - 1) : 5'(SNES_BITS - 1);

  always_ff @(posedge clk) begin
    valid <= 1'b0;
    if (reset) begin
      state     <= IDLE;
      ptype     <= PAD_NES;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b1;
      buttons   <= '0;
      busy      <= 1'b0;
      phase     <= '0;
      bit_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tick && poll_en) begin
            if (!sel[1]) begin
              ptype     <= pad_type_e'(sel);
              state     <= LATCH;
              pad_latch <= 1'b1;
              busy      <= 1'b1;
              phase     <= '0;
              bit_idx   <= '0;
            end else begin
              buttons <= '0;
            end
          end
        end
        LATCH: begin
          if (phase == LATCH_LAST) begin
            phase     <= '0;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b0;
            state     <= CLK_LO;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        CLK_LO: begin
          // Sample as late as possible in the low phase so the pad has settled.
          if (phase == HALF_LAST) begin
            phase                 <= '0;
            shift[bit_idx[3:0]]   <= sync_p1;
            pad_clk               <= 1'b1;
            state                 <= CLK_HI;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        CLK_HI: begin
          if (phase == HALF_LAST) begin
            phase <= '0;
            if (bit_idx == last_bit) begin
              state   <= DONE;
              buttons <= pad_buttons(ptype, shift);
              valid   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              pad_clk <= 1'b0;
              state   <= CLK_LO;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pad_poll_sequencer.sv
// Directed bench for pad_poll_sequencer with a behavioural shift-register pad.
module tb_pad_poll_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, poll_en, pad_data;
  logic [1:0]  sel;
  logic        pad_latch, pad_clk, valid, busy;
  logic [15:0] buttons;

  logic        reset_f, poll_en_f, pad_data_f;
  logic [1:0]  sel_f;
  logic        latch_f, pclk_f, valid_f, busy_f;
  logic [15:0] buttons_f;

  pad_poll_sequencer #(.POLL_CYC(200), .LATCH_CYC(8), .HALF_CYC(4)) dut (
    .clk(clk), .reset(reset), .sel(sel), .poll_en(poll_en), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk), .buttons(buttons), .valid(valid), .busy(busy)
  );

  pad_poll_sequencer #(.POLL_CYC(100), .LATCH_CYC(8), .HALF_CYC(4)) dut_fast (
    .clk(clk), .reset(reset_f), .sel(sel_f), .poll_en(poll_en_f), .pad_data(pad_data_f),
    .pad_latch(latch_f), .pad_clk(pclk_f), .buttons(buttons_f), .valid(valid_f), .busy(busy_f)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pad model: parallel load while latched, shift toward bit 0 on pad_clk rise
  logic [15:0] pad_word;
  logic [15:0] pad_sr    = 16'hFFFF;
  logic        prev_pclk = 1'b1;
  always @(posedge clk) begin
    prev_pclk <= pad_clk;
    if (pad_latch)                   pad_sr <= pad_word;
    else if (pad_clk && !prev_pclk)  pad_sr <= {1'b1, pad_sr[15:1]};
  end
  assign pad_data = pad_sr[0];

  int   lo_pulses = 0, latch_len = 0, bad = 0, vcnt = 0;
  logic prev_l = 1'b0, prev_c = 1'b1;
  always @(negedge clk) begin
    if (pad_latch && !prev_l) begin
      lo_pulses <= 0;
      latch_len <= 1;
    end else if (pad_latch) begin
      latch_len <= latch_len + 1;
    end
    if (!pad_clk && prev_c) lo_pulses <= lo_pulses + 1;
    if (pad_latch && !pad_clk) bad <= bad + 1;
    if (valid) vcnt <= vcnt + 1;
    prev_l <= pad_latch;
    prev_c <= pad_clk;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_latch(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (pad_latch) begin at = cyc; break; end
    end
  endtask

  task automatic wait_valid(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (valid) begin at = cyc; break; end
    end
  endtask

  int rel, t, t2, t3, t3b, t5, v, vb, nl, relf, k, rises;
  int vf[3];
  logic pl;

  initial begin
    reset = 1'b1; sel = 2'b00; poll_en = 1'b0; pad_word = 16'hFFFF;
    reset_f = 1'b1; sel_f = 2'b01; poll_en_f = 1'b1; pad_data_f = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_latch", pad_latch, 0);
    chk("rst_clk", pad_clk, 1);
    chk("rst_buttons", buttons, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);

    // 1: NES, A+Start
    poll_en = 1'b1; pad_word = 16'hFFF6; reset = 1'b0; rel = cyc;
    wait_latch(250, t);
    chk("t1_latch_time", t, rel + 200);
    chk("t1_busy", busy, 1);
    wait_valid(200, v);
    chk("t1_valid_time", v, t + 72);
    chk("t1_buttons", buttons, 16'h0009);
    @(negedge clk);
    chk("t1_pulses", lo_pulses, 8);
    chk("t1_latch_len", latch_len, 8);
    chk("t1_valid_pulse", valid, 0);
    chk("t1_idle_busy", busy, 0);

    // 2: SNES, B+R
    sel = 2'b01; pad_word = 16'hF7FE;
    wait_latch(250, t2);
    chk("t2_latch_time", t2, t + 200);
    wait_valid(300, v);
    chk("t2_valid_time", v, t2 + 136);
    chk("t2_buttons", buttons, 16'h0801);
    chk("t2_upper", buttons[15:12], 0);
    @(negedge clk);
    chk("t2_pulses", lo_pulses, 16);

    // 3: sel flips mid-SNES frame
    wait_latch(250, t3);
    chk("t3_latch_time", t3, t2 + 200);
    repeat (20) @(negedge clk);
    sel = 2'b00; pad_word = 16'hFFF6;
    wait_valid(300, v);
    chk("t3_valid_time", v, t3 + 136);
    chk("t3_buttons", buttons, 16'h0801);
    @(negedge clk);
    chk("t3_pulses", lo_pulses, 16);
    wait_latch(250, t3b);
    chk("t3_nes_latch", t3b, t3 + 200);
    wait_valid(200, v);
    chk("t3_nes_valid", v, t3b + 72);
    chk("t3_nes_buttons", buttons, 16'h0009);
    @(negedge clk);
    chk("t3_nes_pulses", lo_pulses, 8);

    // 4: no pad selected, then polling disabled
    sel = 2'b11; vb = vcnt; nl = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pad_latch) nl++;
    end
    @(negedge clk);
    chk("t4_none_latch", nl, 0);
    chk("t4_none_buttons", buttons, 0);
    chk("t4_none_valid", vcnt, vb);
    poll_en = 1'b0; sel = 2'b00; nl = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (pad_latch) nl++;
    end
    @(negedge clk);
    chk("t4_dis_latch", nl, 0);
    chk("t4_dis_valid", vcnt, vb);

    // 5: reset during bit 5 of an NES frame
    poll_en = 1'b1;
    wait_latch(250, t5);
    chk("t5_latch_seen", (t5 > 0), 1);
    while (cyc < t5 + 50) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_latch", pad_latch, 0);
    chk("t5_clk", pad_clk, 1);
    chk("t5_busy", busy, 0);
    chk("t5_buttons", buttons, 0);
    chk("t5_valid", valid, 0);
    vb = vcnt; reset = 1'b0; rel = cyc;
    wait_latch(250, t);
    chk("t5_relatch", t, rel + 200);
    chk("t5_no_valid", vcnt, vb);
    wait_valid(200, v);
    chk("t5_valid_time", v, t + 72);
    chk("t5_buttons_after", buttons, 16'h0009);
    chk("clk_latch_overlap", bad, 0);

    // 6: frame longer than poll period
    reset_f = 1'b0; relf = cyc; k = 0; rises = 0; pl = 1'b0;
    vf[0] = -1; vf[1] = -1; vf[2] = -1;
    for (int i = 0; i < 800 && k < 3; i++) begin
      @(negedge clk);
      if (latch_f && !pl) rises++;
      pl = latch_f;
      if (valid_f) begin vf[k] = cyc; k++; end
    end
    chk("t6_valid_count", k, 3);
    chk("t6_first_valid", vf[0], relf + 236);
    chk("t6_spacing1", vf[1] - vf[0], 200);
    chk("t6_spacing2", vf[2] - vf[1], 200);
    chk("t6_frames", rises, 3);
    chk("t6_buttons", buttons_f, 16'hFFFF);
    @(negedge clk);
    chk("t6_busy", busy_f, 0);
    chk("t6_clk", pclk_f, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
